// File: rtl/spi_pkg.sv
// spi_pkg
//   Shared constants for the SPI peripheral slice: word size, bit-counter
//   width, idle fill byte and the IDLE/SHIFT state encoding.
//   No ports (package).
package spi_pkg;

    localparam int unsigned SPI_WORD_BITS = 8;
    localparam int unsigned BIT_CNT_W     = $clog2(SPI_WORD_BITS);

    localparam logic [SPI_WORD_BITS-1:0] TX_IDLE_BYTE = '0;

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

endpackage

// File: rtl/spi_sync_edge.sv
// spi_sync_edge
//   SYNC_STAGES-deep flop synchronizer for one asynchronous input, followed
//   by a rise/fall detector on the last two synchronized samples.
//   Edge pulses are registered, so a pin edge shows up as a one-cycle
//   pulse SYNC_STAGES + 1 cycles later; o_sync is aligned with the pulses.
// Ports:
//   i_clk    system clock
//   i_rst_n  synchronous active-low reset (chain loads RST_VAL)
//   i_async  asynchronous input
//   o_sync   synchronized level (same latency as the edge pulses)
//   o_rise   one-cycle rising-edge pulse
//   o_fall   one-cycle falling-edge pulse
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        RST_VAL     = 1'b0
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_async,
    output logic o_sync,
    output logic o_rise,
    output logic o_fall
);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   prev_q;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync_q <= {SYNC_STAGES{RST_VAL}};
            prev_q <= RST_VAL;
            o_rise <= 1'b0;
            o_fall <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], i_async};
            prev_q <= sync_q[SYNC_STAGES-1];
            o_rise <= sync_q[SYNC_STAGES-1] & ~prev_q;
            o_fall <= ~sync_q[SYNC_STAGES-1] & prev_q;
        end
    end

    assign o_sync = prev_q;

endmodule

// File: rtl/spi_peripheral.sv
// spi_peripheral
//   SPI mode-0 (CPOL=0, CPHA=0) peripheral. SCLK/CS_n/MOSI are asynchronous
//   and oversampled on i_clk (f_i_clk >= 10 x f_sclk). 8-bit words, MSB
//   first in both directions; back-to-back words while CS_n stays low.
//   Optional feature macro: SPI_PERIPHERAL_OVERRUN_EN (sticky overrun flag);
//   when undefined o_overrun is tied low.
// Ports:
//   i_clk, i_rst_n          system clock, synchronous active-low reset
//   i_sclk, i_cs_n, i_mosi  SPI bus inputs (async)
//   o_miso, o_miso_oe       MISO data and output enable (high while selected)
//   i_tx_data, i_tx_valid   TX holding-register write
//   o_tx_ready              TX holding register empty
//   o_rx_data, o_rx_valid   last received byte, held until i_rx_ack
//   i_rx_ack                clears o_rx_valid
//   o_busy                  synchronized chip select active
//   o_overrun               sticky overrun flag
module spi_peripheral
    import spi_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic                     i_sclk,
    input  logic                     i_cs_n,
    input  logic                     i_mosi,
    output logic                     o_miso,
    output logic                     o_miso_oe,
    input  logic [SPI_WORD_BITS-1:0] i_tx_data,
    input  logic                     i_tx_valid,
    output logic                     o_tx_ready,
    output logic [SPI_WORD_BITS-1:0] o_rx_data,
    output logic                     o_rx_valid,
    input  logic                     i_rx_ack,
    output logic                     o_busy,
    output logic                     o_overrun
);

    localparam logic [BIT_CNT_W-1:0] LAST_BIT = BIT_CNT_W'(SPI_WORD_BITS - 1);
    localparam logic [BIT_CNT_W-1:0] CNT_ONE  = BIT_CNT_W'(1);

    logic sclk_rise, sclk_fall, unused_sclk_level;
    logic cs_level, cs_rise, cs_fall;

    logic [SYNC_STAGES-1:0]   mosi_sync_q;
    logic [0:0]               state_q;
    logic [BIT_CNT_W-1:0]     bit_cnt_q;
    logic [SPI_WORD_BITS-1:0] shift_tx_q;
    logic [SPI_WORD_BITS-1:0] shift_rx_q;
    logic [SPI_WORD_BITS-1:0] hold_q;
    logic                     hold_full_q;
    logic                     rst_done_q;

    logic                     mosi_s;
    logic                     start, stop, active, bit_rise, bit_fall;
    logic                     tx_write, tx_consume, word_done;
    logic [SPI_WORD_BITS-1:0] load_byte, rx_word;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sclk_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_sclk),
        .o_sync  (unused_sclk_level),
        .o_rise  (sclk_rise),
        .o_fall  (sclk_fall)
    );

    // CS_n resets to its deasserted level so reset release cannot fake a
    // select edge while the bus is idle.
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_cs_sync (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .i_async (i_cs_n),
        .o_sync  (cs_level),
        .o_rise  (cs_rise),
        .o_fall  (cs_fall)
    );

    assign o_busy = ~cs_level;

    // o_tx_ready is held low through reset and rises one cycle after release.
    assign o_tx_ready = rst_done_q & ~hold_full_q;

    always_comb begin
        mosi_s     = mosi_sync_q[SYNC_STAGES-1];
        start      = (state_q == ST_IDLE) && cs_fall;
        stop       = (state_q == ST_SHIFT) && cs_rise;
        active     = (state_q == ST_SHIFT) && !cs_rise;
        bit_rise   = active && sclk_rise;
        bit_fall   = active && sclk_fall;
        tx_write   = i_tx_valid && o_tx_ready;
        tx_consume = start || (bit_fall && (bit_cnt_q == '0));
        word_done  = bit_rise && (bit_cnt_q == LAST_BIT);
        load_byte  = hold_full_q ? hold_q : TX_IDLE_BYTE;
        rx_word    = {shift_rx_q[SPI_WORD_BITS-2:0], mosi_s};
    end

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            mosi_sync_q <= '0;
            state_q     <= ST_IDLE;
            bit_cnt_q   <= '0;
            shift_tx_q  <= '0;
            shift_rx_q  <= '0;
            hold_q      <= '0;
            hold_full_q <= 1'b0;
            rst_done_q  <= 1'b0;
            o_miso      <= 1'b0;
            o_miso_oe   <= 1'b0;
            o_rx_data   <= '0;
            o_rx_valid  <= 1'b0;
        end else begin
            rst_done_q  <= 1'b1;
            mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], i_mosi};

            // A write can only happen while empty, so a same-cycle consume
            // takes the idle byte and the write lands afterwards.
            if (tx_consume) begin
                hold_full_q <= 1'b0;
            end
            if (tx_write) begin
                hold_q      <= i_tx_data;
                hold_full_q <= 1'b1;
            end

            if (start) begin
                state_q    <= ST_SHIFT;
                shift_tx_q <= load_byte;
                o_miso     <= load_byte[SPI_WORD_BITS-1];
                o_miso_oe  <= 1'b1;
                bit_cnt_q  <= '0;
            end else if (stop) begin
                state_q   <= ST_IDLE;
                o_miso    <= 1'b0;
                o_miso_oe <= 1'b0;
                bit_cnt_q <= '0;
            end else begin
                if (bit_rise) begin
                    shift_rx_q <= rx_word;
                    bit_cnt_q  <= word_done ? '0 : bit_cnt_q + CNT_ONE;
                end
                if (bit_fall) begin
                    if (bit_cnt_q == '0) begin
                        shift_tx_q <= load_byte;
                        o_miso     <= load_byte[SPI_WORD_BITS-1];
                    end else begin
                        shift_tx_q <= shift_tx_q << 1;
                        o_miso     <= shift_tx_q[SPI_WORD_BITS-2];
                    end
                end
            end

            // A completing word wins over a same-cycle ack.
            if (i_rx_ack) begin
                o_rx_valid <= 1'b0;
            end
            if (word_done) begin
                o_rx_data  <= rx_word;
                o_rx_valid <= 1'b1;
            end
        end
    end

`ifdef SPI_PERIPHERAL_OVERRUN_EN
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            o_overrun <= 1'b0;
        end else if (word_done && o_rx_valid && !i_rx_ack) begin
            o_overrun <= 1'b1;
        end else if (i_rx_ack) begin
            o_overrun <= 1'b0;
        end
    end
`else
    assign o_overrun = 1'b0;
`endif

endmodule

// File: tb/tb_spi_peripheral.sv
// tb_spi_peripheral
//   Directed self-checking bench for spi_peripheral. Acts as a mode-0 SPI
//   controller with SCLK half-period of 10 i_clk cycles (f_sclk = f_i_clk/20).
module tb_spi_peripheral;

    localparam int unsigned SYNC_STAGES = 2;
    localparam int          HALF        = 10;

`ifdef SPI_PERIPHERAL_OVERRUN_EN
    localparam logic EXP_OVR = 1'b1;
`else
    localparam logic EXP_OVR = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sclk, cs_n, mosi;
    logic       miso, miso_oe;
    logic [7:0] tx_data;
    logic       tx_valid, tx_ready;
    logic [7:0] rx_data;
    logic       rx_valid, rx_ack;
    logic       busy, overrun;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    spi_peripheral #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_sclk     (sclk),
        .i_cs_n     (cs_n),
        .i_mosi     (mosi),
        .o_miso     (miso),
        .o_miso_oe  (miso_oe),
        .i_tx_data  (tx_data),
        .i_tx_valid (tx_valid),
        .o_tx_ready (tx_ready),
        .o_rx_data  (rx_data),
        .o_rx_valid (rx_valid),
        .i_rx_ack   (rx_ack),
        .o_busy     (busy),
        .o_overrun  (overrun)
    );

    // ---------------- bus drivers ----------------
    task automatic cs_low();
        @(negedge clk);
        cs_n = 1'b0;
        repeat (HALF) @(negedge clk);
    endtask

    task automatic cs_high();
        repeat (HALF) @(negedge clk);
        cs_n = 1'b1;
        repeat (HALF) @(negedge clk);
    endtask

    // Shifts nbits MSB-first; returns captured MISO bits and the number of
    // cycles from the SCLK rise to the first cycle o_rx_valid is seen high.
    task automatic spi_bits(input logic [7:0] mo, input int nbits,
                            output logic [7:0] mi, output int lat);
        mi  = '0;
        lat = 0;
        for (int i = 0; i < nbits; i++) begin
            mosi = mo[7-i];
            repeat (HALF) @(negedge clk);
            sclk      = 1'b1;
            mi[7-i]   = miso;
            for (int c = 1; c <= HALF; c++) begin
                @(negedge clk);
                if (rx_valid && lat == 0) lat = c;
            end
            sclk = 1'b0;
        end
    endtask

    task automatic tx_write(input logic [7:0] b);
        tx_data  = b;
        tx_valid = 1'b1;
        @(negedge clk);
        tx_valid = 1'b0;
    endtask

    task automatic rx_ack_pulse();
        rx_ack = 1'b1;
        @(negedge clk);
        rx_ack = 1'b0;
        @(negedge clk);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst_n = 1'b0; cs_n = 1'b1; sclk = 1'b0; mosi = 1'b0;
        tx_data = '0; tx_valid = 1'b0; rx_ack = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++; if (miso !== 1'b0) $display("FAIL reset_miso: got %b expected 0", miso); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL reset_oe: got %b expected 0", miso_oe); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL reset_rx_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL reset_rx_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else n_pass++;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL reset_tx_ready: got %b expected 0", tx_ready); else n_pass++;
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL release_tx_ready: got %b expected 1", tx_ready); else n_pass++;
    endtask

    task automatic test_single_byte();
        logic [7:0] mi;
        int         lat;
        tx_write(8'hA5);
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL single_ready_full: got %b expected 0", tx_ready); else n_pass++;
        cs_low();
        n_checks++; if (busy !== 1'b1) $display("FAIL single_busy: got %b expected 1", busy); else n_pass++;
        n_checks++; if (miso_oe !== 1'b1) $display("FAIL single_oe: got %b expected 1", miso_oe); else n_pass++;
        n_checks++; if (miso !== 1'b1) $display("FAIL single_first_bit: got %b expected 1", miso); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL single_ready_consumed: got %b expected 1", tx_ready); else n_pass++;
        spi_bits(8'h3C, 8, mi, lat);
        n_checks++; if (mi !== 8'hA5) $display("FAIL single_miso_byte: got %h expected a5", mi); else n_pass++;
        n_checks++; if (rx_data !== 8'h3C) $display("FAIL single_rx_data: got %h expected 3c", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL single_rx_valid: got %b expected 1", rx_valid); else n_pass++;
        n_checks++; if (lat !== SYNC_STAGES + 2) $display("FAIL single_rx_latency: got %0d expected %0d", lat, SYNC_STAGES + 2); else n_pass++;
        cs_high();
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL single_oe_off: got %b expected 0", miso_oe); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL single_busy_off: got %b expected 0", busy); else n_pass++;
        rx_ack_pulse();
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL single_ack: got %b expected 0", rx_valid); else n_pass++;
    endtask

    task automatic test_back_to_back();
        logic [7:0] mi;
        int         lat;
        tx_write(8'h11);
        cs_low();
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready_after_load: got %b expected 1", tx_ready); else n_pass++;
        tx_write(8'h22);
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL b2b_ready_full: got %b expected 0", tx_ready); else n_pass++;
        spi_bits(8'hF0, 8, mi, lat);
        n_checks++; if (mi !== 8'h11) $display("FAIL b2b_miso0: got %h expected 11", mi); else n_pass++;
        n_checks++; if (rx_data !== 8'hF0) $display("FAIL b2b_rx0: got %h expected f0", rx_data); else n_pass++;
        repeat (6) @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL b2b_ready_after_reload: got %b expected 1", tx_ready); else n_pass++;
        rx_ack_pulse();
        spi_bits(8'h0F, 8, mi, lat);
        n_checks++; if (mi !== 8'h22) $display("FAIL b2b_miso1: got %h expected 22", mi); else n_pass++;
        n_checks++; if (rx_data !== 8'h0F) $display("FAIL b2b_rx1: got %h expected 0f", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL b2b_rx1_valid: got %b expected 1", rx_valid); else n_pass++;
        cs_high();
        rx_ack_pulse();
    endtask

    task automatic test_empty_tx();
        logic [7:0] mi;
        int         lat;
        cs_low();
        spi_bits(8'h5A, 8, mi, lat);
        n_checks++; if (mi !== 8'h00) $display("FAIL empty_miso: got %h expected 00", mi); else n_pass++;
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL empty_ready: got %b expected 1", tx_ready); else n_pass++;
        n_checks++; if (rx_data !== 8'h5A) $display("FAIL empty_rx: got %h expected 5a", rx_data); else n_pass++;
        cs_high();
        rx_ack_pulse();
    endtask

    task automatic test_abort();
        logic [7:0] mi;
        int         lat;
        cs_low();
        spi_bits(8'hFF, 5, mi, lat);
        cs_high();
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL abort_no_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL abort_oe: got %b expected 0", miso_oe); else n_pass++;
        n_checks++; if (miso !== 1'b0) $display("FAIL abort_miso: got %b expected 0", miso); else n_pass++;
        cs_low();
        spi_bits(8'h81, 8, mi, lat);
        n_checks++; if (rx_data !== 8'h81) $display("FAIL abort_next_rx: got %h expected 81", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL abort_next_valid: got %b expected 1", rx_valid); else n_pass++;
        cs_high();
        rx_ack_pulse();
    endtask

    task automatic test_overrun();
        logic [7:0] mi;
        int         lat;
        cs_low();
        spi_bits(8'hC3, 8, mi, lat);
        spi_bits(8'h96, 8, mi, lat);
        n_checks++; if (rx_data !== 8'h96) $display("FAIL ovr_rx_data: got %h expected 96", rx_data); else n_pass++;
        n_checks++; if (rx_valid !== 1'b1) $display("FAIL ovr_rx_valid: got %b expected 1", rx_valid); else n_pass++;
        n_checks++; if (overrun !== EXP_OVR) $display("FAIL ovr_flag: got %b expected %b", overrun, EXP_OVR); else n_pass++;
        cs_high();
        rx_ack_pulse();
        n_checks++; if (rx_valid !== 1'b0) $display("FAIL ovr_ack_valid: got %b expected 0", rx_valid); else n_pass++;
        n_checks++; if (overrun !== 1'b0) $display("FAIL ovr_ack_flag: got %b expected 0", overrun); else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic [7:0] mi;
        int         lat;
        cs_low();
        spi_bits(8'hE7, 3, mi, lat);
        tx_write(8'h77);
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL rstmid_ready_full: got %b expected 0", tx_ready); else n_pass++;
        rst_n = 1'b0;
        @(negedge clk);
        n_checks++; if (miso_oe !== 1'b0) $display("FAIL rstmid_oe: got %b expected 0", miso_oe); else n_pass++;
        n_checks++; if (miso !== 1'b0) $display("FAIL rstmid_miso: got %b expected 0", miso); else n_pass++;
        n_checks++; if (rx_data !== 8'h00) $display("FAIL rstmid_rx_data: got %h expected 00", rx_data); else n_pass++;
        n_checks++; if (busy !== 1'b0) $display("FAIL rstmid_busy: got %b expected 0", busy); else n_pass++;
        n_checks++; if (tx_ready !== 1'b0) $display("FAIL rstmid_ready: got %b expected 0", tx_ready); else n_pass++;
        cs_n = 1'b1;
        sclk = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        n_checks++; if (tx_ready !== 1'b1) $display("FAIL rstmid_release_ready: got %b expected 1", tx_ready); else n_pass++;
        cs_low();
        spi_bits(8'h42, 8, mi, lat);
        n_checks++; if (mi !== 8'h00) $display("FAIL rstmid_hold_emptied: got %h expected 00", mi); else n_pass++;
        n_checks++; if (rx_data !== 8'h42) $display("FAIL rstmid_rx_after: got %h expected 42", rx_data); else n_pass++;
        cs_high();
        rx_ack_pulse();
    endtask

    initial begin
        test_reset();
        test_single_byte();
        test_back_to_back();
        test_empty_tx();
        test_abort();
        test_overrun();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
